fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle instruction fetch and PC sequencer; the producer side of the opcode-to-control interface.
- Fetches instruction words over a req/ack memory handshake and presents the opcode to the control decoder.
- Consumes the decoder's branch, jump and return strobes plus ALU flags, and computes the next PC.
- Holds a small hardware return-address stack for jmp/ret.

Parameters:
ADDR_W, 10, PC and instruction-memory address width
INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1:INSTR_W-6], offset/target = instr[ADDR_W-1:0]
STACK_DEPTH, 4, return-address stack entries (power of 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  leave IDLE and begin fetching at PC
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ack  in  1  read data valid
imem_rdata  in  INSTR_W  instruction word
opcode  out  6  to decoder, = ir[INSTR_W-1:INSTR_W-6]
instr_valid  out  1  opcode valid (DECODE and EXEC)
brz, brn, brc, bro, bra, jmp, ret  in  1 each  decoder strobes, sampled in EXEC
flag_z, flag_n, flag_c, flag_o  in  1 each  ALU flags, sampled in EXEC
exec_stall  in  1  hold in EXEC (datapath/memory busy)
pc  out  ADDR_W  current PC
retired  out  1  one-cycle pulse when an instruction completes
err  out  1  sticky stack overflow/underflow error

Behaviour:
- Reset (async): state=IDLE; pc=0; ir=0; sp=0; stack contents=0; all outputs 0.
- States: IDLE, FETCH, DECODE, EXEC, ERROR.
- IDLE:
  - start=1 -> FETCH next cycle. Otherwise stay.
  - imem_req=0.
- FETCH:
  - imem_req=1; imem_addr=pc, stable until ack.
  - imem_ack=1 -> ir<=imem_rdata -> DECODE.
  - An ack in the same cycle req first rises is legal.
  - imem_ack outside FETCH is ignored.
- DECODE:
  - One cycle; instr_valid=1; opcode driven from ir.
  - Always -> EXEC.
- EXEC:
  - instr_valid=1.
  - exec_stall=1 -> stay; pc and stack unchanged; retired=0.
  - exec_stall=0 -> update pc, pulse retired next cycle with state -> FETCH.
- Next-PC priority when several strobes are high:
  - ret: pop; pc<=stack[sp-1]; sp-1.
  - jmp: push pc+1; pc<=ir[ADDR_W-1:0] (absolute).
  - bra: pc<=pc+1+sext(ir[ADDR_W-1:0]).
  - brz&flag_z, brn&flag_n, brc&flag_c, bro&flag_o: same relative target.
  - else: pc<=pc+1.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W, wrapping silently (pc=2^ADDR_W-1 + 1 -> 0). Offset is two's-complement ADDR_W bits.
- Stack: sp ranges 0..STACK_DEPTH.
  - Full = (sp==STACK_DEPTH); push when full -> no write, err<=1, state -> ERROR.
  - Empty = (sp==0); ret when empty -> err<=1, state -> ERROR.
  - On either error pc is unchanged and retired stays 0.
- ERROR: imem_req=0, instr_valid=0, err=1. Only rst exits.
- Reset mid-operation: any state returns to IDLE immediately; any outstanding request is abandoned; a late ack is ignored.
- Throughput: 3 cycles per instruction with zero-wait ack and no stall.

Test Plan:
- Reset then start, memory with ack on first req cycle, program of three non-branch opcodes:
  - imem_addr sequence 0,1,2.
  - opcode matches each word in DECODE.
  - retired pulses every 3 cycles; pc=3 after third.
- Ack delayed 4 cycles at addr 5: imem_req held 5 cycles with imem_addr=5 stable; ir loaded only on ack.
- Branches at pc=10 with offset 0x3FE (-2):
  - brz=1, flag_z=1 -> pc=9.
  - brz=1, flag_z=0 -> pc=11.
  - bra=1 -> pc=9.
  - pc=1023 non-branch -> pc=0.
- jmp target 0x040 at pc=7 -> pc=0x040, sp=1; then ret -> pc=8, sp=0. jmp and ret high together -> ret wins.
- Stack errors:
  - 5 nested jmp with STACK_DEPTH=4 -> err=1 on fifth, state ERROR, imem_req=0.
  - After reset, ret with empty stack -> err=1.
  - rst clears err.
- exec_stall and reset:
  - exec_stall high 3 cycles in EXEC -> pc frozen, retired delayed 3 cycles.
  - rst asserted mid-FETCH -> outputs 0 immediately, IDLE.
  - Ack arriving after reset release is ignored.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch/decode bus: instruction-memory handshake plus opcode, decoder strobes and ALU flags.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [5:0]         opcode;
  logic               instr_valid;
  logic               brz, brn, brc, bro, bra, jmp, ret;
  logic               flag_z, flag_n, flag_c, flag_o;

  modport master (
    output imem_req, imem_addr, opcode, instr_valid,
    input  imem_ack, imem_rdata,
    input  brz, brn, brc, bro, bra, jmp, ret,
    input  flag_z, flag_n, flag_c, flag_o
  );

  modport slave (
    input  imem_req, imem_addr, opcode, instr_valid,
    output imem_ack, imem_rdata,
    output brz, brn, brc, bro, bra, jmp, ret,
    output flag_z, flag_n, flag_c, flag_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute PC sequencer with a small return-address stack.
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_req high at pc, waiting for ack
// DECODE | opcode presented for one cycle
// EXEC   | strobes sampled, next pc computed unless stalled
// ERROR  | stack fault, held until reset
module fetch_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_exec_stall,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_retired,
  output logic              o_err
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ERROR} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic [SP_W-1:0]     r_sp, w_sp_dec;
  logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];
  logic                r_retired, r_err;
  logic                w_push, w_pop, w_fault, w_retire, w_taken;
  logic [ADDR_W-1:0]   w_off, w_pc_inc, w_rel;

  assign w_off    = r_ir[ADDR_W-1:0];
  assign w_pc_inc = r_pc + 1'b1;
  assign w_rel    = w_pc_inc + w_off;
  assign w_sp_dec = r_sp - 1'b1;
  assign w_taken  = bus.bra | (bus.brz & bus.flag_z) | (bus.brn & bus.flag_n) |
                    (bus.brc & bus.flag_c) | (bus.bro & bus.flag_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_fault     = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_FETCH;
      S_FETCH:  if (bus.imem_ack) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (!i_exec_stall) begin
          // ret outranks jmp, which outranks every branch form
          if (bus.ret) begin
            if (r_sp == '0) w_fault = 1'b1;
            else begin
              w_pop    = 1'b1;
              w_pc_nxt = r_stack[w_sp_dec[SP_W-2:0]];
            end
          end else if (bus.jmp) begin
            if (r_sp == SP_FULL) w_fault = 1'b1;
            else begin
              w_push   = 1'b1;
              w_pc_nxt = w_off;
            end
          end else if (w_taken) begin
            w_pc_nxt = w_rel;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
          if (w_fault) w_state_nxt = S_ERROR;
          else begin
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_ERROR:  w_state_nxt = S_ERROR;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_sp      <= '0;
      r_retired <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_retired <= w_retire;
      r_pc      <= w_pc_nxt;
      if (r_state == S_FETCH && bus.imem_ack) r_ir <= bus.imem_rdata;
      if (w_push) begin
        r_stack[r_sp[SP_W-2:0]] <= w_pc_inc;
        r_sp                    <= r_sp + 1'b1;
      end else if (w_pop) begin
        r_sp <= w_sp_dec;
      end
      if (w_fault) r_err <= 1'b1;
    end
  end

  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.opcode      = r_ir[INSTR_W-1 -: 6];
  assign bus.instr_valid = (r_state == S_DECODE) || (r_state == S_EXEC);
  assign o_pc            = r_pc;
  assign o_retired       = r_retired;
  assign o_err           = r_err;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instruction-level PC/stack model plus per-cycle output compare.
module tb_fetch_sequencer;
  localparam int AW    = 10;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] pc;
  logic          retired, err;

  fetch_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .STACK_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_exec_stall (stall),
    .bus          (bus.master),
    .o_pc         (pc),
    .o_retired    (retired),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [1024];
  int            m_pc;
  logic [IW-1:0] m_ir;
  bit            m_req, m_iv, m_ret, m_err, chk_en;
  int            m_stack[$];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", int'(bus.imem_req), int'(m_req));
      if (m_req) chk("imem_addr", int'(bus.imem_addr), m_pc);
      chk("instr_valid", int'(bus.instr_valid), int'(m_iv));
      if (m_iv) chk("opcode", int'(bus.opcode), int'(m_ir[IW-1 -: 6]));
      chk("pc", int'(pc), m_pc);
      chk("retired", int'(retired), int'(m_ret));
      chk("err", int'(err), int'(m_err));
    end
  end

  // st = {ret,jmp,bra,brz,brn,brc,bro}, fl = {z,n,c,o}; returns 1 on a stack fault
  function automatic bit model_exec(input logic [6:0] st, input logic [3:0] fl);
    int tgt, off;
    tgt = int'(m_ir[AW-1:0]);
    off = (tgt >= 512) ? tgt - 1024 : tgt;
    if (st[6]) begin
      if (m_stack.size() == 0) return 1'b1;
      m_pc = m_stack.pop_back();
    end else if (st[5]) begin
      if (m_stack.size() == DEPTH) return 1'b1;
      m_stack.push_back((m_pc + 1) % 1024);
      m_pc = tgt;
    end else if (st[4] || (st[3] && fl[3]) || (st[2] && fl[2]) ||
                 (st[1] && fl[1]) || (st[0] && fl[0])) begin
      m_pc = (m_pc + 1 + off + 1024) % 1024;
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
    return 1'b0;
  endfunction

  task automatic drive_ctl(input logic [6:0] st, input logic [3:0] fl);
    {bus.ret, bus.jmp, bus.bra, bus.brz, bus.brn, bus.brc, bus.bro} = st;
    {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_o} = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; stall = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    drive_ctl(7'd0, 4'd0);
    m_pc = 0; m_ir = '0; m_req = 0; m_iv = 0; m_ret = 0; m_err = 0;
    m_stack.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_req = 1;
  endtask

  // Entry and exit: 1 time unit after a rising edge, DUT in FETCH on entry.
  task automatic run_instr(input int ack_wait, input int stall_cyc,
                           input logic [6:0] st, input logic [3:0] fl);
    bit fault;
    for (int k = 0; k <= ack_wait; k++) begin
      bus.imem_rdata = (k == ack_wait) ? mem[m_pc] : ~mem[m_pc];
      bus.imem_ack   = (k == ack_wait);
      @(posedge clk); #1;
      m_ret = 0;
    end
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = ~mem[m_pc];
    m_ir  = mem[m_pc];
    m_req = 0;
    m_iv  = 1;
    drive_ctl(st, fl);
    stall = (stall_cyc > 0);
    @(posedge clk); #1;
    for (int k = 0; k < stall_cyc; k++) begin
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(posedge clk); #1;
    fault = model_exec(st, fl);
    drive_ctl(7'd0, 4'd0);
    m_iv = 0;
    if (fault) begin
      m_err = 1; m_req = 0; m_ret = 0;
    end else begin
      m_req = 1; m_ret = 1;
    end
  endtask

  localparam logic [6:0] NB  = 7'b0000000;
  localparam logic [6:0] RET = 7'b1000000;
  localparam logic [6:0] JMP = 7'b0100000;
  localparam logic [6:0] BRA = 7'b0010000;
  localparam logic [6:0] BRZ = 7'b0001000;
  localparam logic [6:0] BRN = 7'b0000100;
  localparam logic [6:0] BRC = 7'b0000010;
  localparam logic [6:0] BRO = 7'b0000001;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = IW'((i * 37 + 11) & 16'hFFFF);
    mem[0]    = {6'h11, 10'd6};
    mem[3]    = {6'h12, 10'd1};
    mem[6]    = {6'h13, 10'd3};
    mem[7]    = {6'h17, 10'h040};
    mem[8]    = {6'h18, 10'h040};
    mem[9]    = {6'h16, 10'h3F5};
    mem[10]   = {6'h14, 10'h3FE};
    mem[11]   = {6'h15, 10'h3FE};
    mem[64]   = {6'h19, 10'h100};
    mem[1022] = {6'h1A, 10'h3FE};

    do_reset();
    chk_en = 1;
    @(posedge clk); #1;
    chk("reset pc", int'(pc), 0);
    chk("reset imem_req", int'(bus.imem_req), 0);

    // three straight-line instructions, zero-wait ack
    do_start();
    run_instr(0, 0, NB, 4'h0);
    run_instr(0, 0, NB, 4'h0);
    run_instr(0, 0, NB, 4'h0);
    chk("pc after three", int'(pc), 3);
    chk("retired after third", int'(retired), 1);

    run_instr(0, 0, BRA, 4'h0);       // 3 -> 5
    chk("bra to 5", int'(pc), 5);
    run_instr(4, 0, NB, 4'h0);        // delayed ack at 5
    chk("after slow fetch", int'(pc), 6);
    run_instr(0, 0, BRA, 4'h0);       // 6 -> 10
    chk("bra to 10", int'(pc), 10);
    run_instr(0, 0, BRZ, 4'h8);       // taken -2
    chk("brz taken", int'(pc), 9);
    run_instr(0, 3, NB, 4'h0);        // stalled 3 cycles
    chk("after stall", int'(pc), 10);
    run_instr(0, 0, BRZ, 4'h7);       // not taken
    chk("brz not taken", int'(pc), 11);
    run_instr(0, 0, BRA, 4'h0);       // 11 -> 10
    run_instr(0, 0, BRA, 4'h0);       // 10 -> 9
    chk("bra -2", int'(pc), 9);
    run_instr(0, 0, BRA, 4'h0);       // 9 - 10 -> 1023
    chk("bra to 1023", int'(pc), 1023);
    run_instr(0, 0, NB, 4'h0);
    chk("pc wrap", int'(pc), 0);
    run_instr(0, 0, BRN, 4'h4);       // 0 -> 7
    chk("brn taken", int'(pc), 7);

    run_instr(0, 0, JMP, 4'h0);
    chk("jmp target", int'(pc), 64);
    run_instr(0, 0, RET, 4'h0);
    chk("ret to 8", int'(pc), 8);
    run_instr(0, 0, JMP, 4'h0);       // push 9
    run_instr(0, 0, JMP | RET, 4'h0);
    chk("ret beats jmp", int'(pc), 9);
    run_instr(0, 0, BRO, 4'hE);       // flag_o clear
    chk("bro not taken", int'(pc), 10);
    run_instr(0, 0, BRC, 4'h2);
    chk("brc taken", int'(pc), 9);
    run_instr(0, 0, NB, 4'h0);

    // nested jmp: 10 -> 1022, then 1022 repeatedly until the stack overflows
    run_instr(0, 0, JMP, 4'h0);
    for (int j = 0; j < 4; j++) run_instr(0, 0, JMP, 4'h0);
    chk("overflow err", int'(err), 1);
    chk("overflow pc held", int'(pc), 1022);
    bus.imem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.imem_ack = 1'b0;
    chk("error req low", int'(bus.imem_req), 0);

    do_reset();
    chk("rst clears err", int'(err), 0);
    do_start();
    run_instr(0, 0, RET, 4'h0);
    chk("underflow err", int'(err), 1);
    chk("underflow pc", int'(pc), 0);

    // reset in the FETCH cycle right after a retire
    do_reset();
    do_start();
    run_instr(0, 0, NB, 4'h0);
    #2;
    rst = 1'b1;
    m_pc = 0; m_ir = '0; m_req = 0; m_iv = 0; m_ret = 0; m_err = 0;
    m_stack.delete();
    #1;
    chk("async rst req", int'(bus.imem_req), 0);
    chk("async rst pc", int'(pc), 0);
    chk("async rst retired", int'(retired), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hFFFF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.imem_ack = 1'b0;
    chk("late ack ignored", int'(bus.instr_valid), 0);
    do_start();
    run_instr(0, 0, NB, 4'h0);
    chk("restart pc", int'(pc), 1);
    @(posedge clk); #1;

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
